// File: rtl/noninterference_trace_monitor_pkg.sv
// Shared types for the noninterference trace monitor: FSM state encoding as seen on state_o.
package noninterference_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TRIPPED = 2'd2,
        ST_DUMP    = 2'd3
    } mon_state_e;

    localparam logic [1:0] STATE_O_IDLE    = 2'd0;
    localparam logic [1:0] STATE_O_ARMED   = 2'd1;
    localparam logic [1:0] STATE_O_TRIPPED = 2'd2;
    localparam logic [1:0] STATE_O_DUMP    = 2'd3;

endpackage

// File: rtl/noninterference_trace_monitor_if.sv
// Signal bundle between the miter-side environment (master) and the trace monitor (slave).
interface noninterference_trace_monitor_if #(
    parameter int IN_W  = 5,
    parameter int CNT_W = 16
);
    logic             arm;
    logic             bad;
    logic [IN_W-1:0]  stim;
    logic             dump_req;
    // Replay handshake: an entry transfers on a rising edge where dump_valid && dump_ready;
    // while dump_valid is high and dump_ready low, dump_data/dump_last hold their values.
    logic             dump_valid;
    logic             dump_ready;
    logic [IN_W-1:0]  dump_data;
    logic             dump_last;
    logic             tripped;
    logic [CNT_W-1:0] trip_cycle;
    logic [CNT_W-1:0] cycle_cnt;
    logic             overflow;
    logic [1:0]       state_o;

    modport master (
        output arm, bad, stim, dump_req, dump_ready,
        input  dump_valid, dump_data, dump_last, tripped, trip_cycle, cycle_cnt, overflow, state_o
    );

    modport slave (
        input  arm, bad, stim, dump_req, dump_ready,
        output dump_valid, dump_data, dump_last, tripped, trip_cycle, cycle_cnt, overflow, state_o
    );
endinterface

// File: rtl/noninterference_trace_monitor_trace_ring.sv
// Ring of the most recent DEPTH stimulus vectors with a saturating occupancy count.
module trace_ring #(
    parameter int IN_W  = 5,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     we,
    input  logic [IN_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [IN_W-1:0]          rd_data,
    output logic [$clog2(DEPTH)-1:0] wptr,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [IN_W-1:0] mem [DEPTH];

    // Storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (we && !clear) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            wptr      <= '0;
            occupancy <= '0;
        end else if (we) begin
            wptr <= wptr + 1'b1;
            if (occupancy != FULL) begin
                occupancy <= occupancy + 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/noninterference_trace_monitor.sv
// Watches the miter's bad flag, records recent stimulus, and replays it as a counterexample.
module noninterference_trace_monitor
    import noninterference_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic                           clock,
    input logic                           reset_n,
    noninterference_trace_monitor_if.slave mon
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mon_state_e       state, state_nxt;
    logic             ring_clear, ring_we, do_trip, start_dump, advance, is_last;
    logic [PTR_W-1:0] wptr, rd_idx;
    logic [PTR_W:0]   occupancy, sent;
    logic [IN_W-1:0]  rd_data;
    logic [CNT_W-1:0] cycle_cnt, trip_cycle;
    logic             tripped, overflow;

    trace_ring #(.IN_W(IN_W), .DEPTH(DEPTH)) u_ring (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (ring_clear),
        .we        (ring_we),
        .wdata     (mon.stim),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .wptr      (wptr),
        .occupancy (occupancy)
    );

    assign is_last = (sent == occupancy - 1'b1);

    always_comb begin
        state_nxt  = state;
        ring_clear = 1'b0;
        ring_we    = 1'b0;
        do_trip    = 1'b0;
        start_dump = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mon.arm) begin
                    ring_clear = 1'b1;
                    state_nxt  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A violation outranks a simultaneous re-arm, and its stimulus is recorded.
                if (mon.bad) begin
                    ring_we   = 1'b1;
                    do_trip   = 1'b1;
                    state_nxt = ST_TRIPPED;
                end else if (mon.arm) begin
                    ring_clear = 1'b1;
                end else begin
                    ring_we = 1'b1;
                end
            end
            ST_TRIPPED: begin
                if (mon.arm) begin
                    ring_clear = 1'b1;
                    state_nxt  = ST_ARMED;
                end else if (mon.dump_req) begin
                    start_dump = 1'b1;
                    state_nxt  = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (mon.dump_ready) begin
                    advance = 1'b1;
                    if (is_last) begin
                        state_nxt = ST_TRIPPED;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cycle_cnt  <= '0;
            trip_cycle <= '0;
            tripped    <= 1'b0;
            overflow   <= 1'b0;
            rd_idx     <= '0;
            sent       <= '0;
        end else begin
            state <= state_nxt;
            if (ring_clear) begin
                cycle_cnt  <= '0;
                trip_cycle <= '0;
                tripped    <= 1'b0;
                overflow   <= 1'b0;
            end else if (ring_we) begin
                if (cycle_cnt == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                end
            end
            if (do_trip) begin
                trip_cycle <= cycle_cnt;
                tripped    <= 1'b1;
            end
            // Once the ring has wrapped, the oldest entry sits at the write pointer.
            if (start_dump) begin
                rd_idx <= (occupancy == FULL) ? wptr : '0;
                sent   <= '0;
            end else if (advance) begin
                rd_idx <= rd_idx + 1'b1;
                sent   <= sent + 1'b1;
            end
        end
    end

    assign mon.dump_valid = (state == ST_DUMP);
    assign mon.dump_data  = mon.dump_valid ? rd_data : '0;
    assign mon.dump_last  = mon.dump_valid && is_last;
    assign mon.tripped    = tripped;
    assign mon.trip_cycle = trip_cycle;
    assign mon.cycle_cnt  = cycle_cnt;
    assign mon.overflow   = overflow;
    assign mon.state_o    = state;
endmodule

// File: tb/tb_noninterference_trace_monitor.sv
// Directed bench for the trace monitor: reset, trip capture, wrap, backpressure, priority, saturation.
module tb_noninterference_trace_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noninterference_trace_monitor_if #(.IN_W(5), .CNT_W(16)) m();
    noninterference_trace_monitor_if #(.IN_W(5), .CNT_W(4))  s();

    noninterference_trace_monitor #(.IN_W(5), .DEPTH(8), .CNT_W(16)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .mon     (m)
    );

    noninterference_trace_monitor #(.IN_W(5), .DEPTH(8), .CNT_W(4)) dut_sat (
        .clock   (clk),
        .reset_n (rst_n),
        .mon     (s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] hist_q[$];
    logic [4:0] exp_q[$];
    logic [4:0] ready_pat = 5'b10010;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic arm_m();
        m.arm = 1'b1;
        @(negedge clk);
        m.arm = 1'b0;
        hist_q.delete();
    endtask

    task automatic step(input logic [4:0] v, input logic b);
        m.stim = v;
        m.bad  = b;
        hist_q.push_back(v);
        if (hist_q.size() > 8) void'(hist_q.pop_front());
        @(negedge clk);
        m.bad = 1'b0;
    endtask

    task automatic dump_trace(input bit bp, input string tag);
        logic [4:0] held;
        logic [4:0] want;
        bit held_ok;
        int k;
        exp_q = hist_q;
        m.dump_req = 1'b1;
        @(negedge clk);
        m.dump_req = 1'b0;
        chk({tag, "_first_valid"}, 32'(m.dump_valid), 1);
        held_ok = 1'b0;
        held    = '0;
        k       = 0;
        while (exp_q.size() > 0 && k < 64) begin
            m.dump_ready = bp ? ready_pat[k % 5] : 1'b1;
            chk({tag, "_valid"}, 32'(m.dump_valid), 1);
            if (held_ok) chk({tag, "_hold"}, 32'(m.dump_data), 32'(held));
            if (m.dump_ready) begin
                want = exp_q.pop_front();
                chk({tag, "_data"}, 32'(m.dump_data), 32'(want));
                chk({tag, "_last"}, 32'(m.dump_last), 32'(exp_q.size() == 0));
                held_ok = 1'b0;
            end else begin
                held    = m.dump_data;
                held_ok = 1'b1;
            end
            k++;
            @(negedge clk);
        end
        m.dump_ready = 1'b0;
        chk({tag, "_drained"}, 32'(exp_q.size()), 0);
        chk({tag, "_end_valid"}, 32'(m.dump_valid), 0);
        chk({tag, "_end_state"}, 32'(m.state_o), 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m.arm = 1'b1; m.bad = 1'b1; m.stim = '0; m.dump_req = 1'b0; m.dump_ready = 1'b0;
        s.arm = 1'b1; s.bad = 1'b1; s.stim = '0; s.dump_req = 1'b0; s.dump_ready = 1'b0;

        // Reset held with arm and bad active.
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(m.state_o), 0);
        chk("rst_tripped", 32'(m.tripped), 0);
        chk("rst_trip_cycle", 32'(m.trip_cycle), 0);
        chk("rst_cycle_cnt", 32'(m.cycle_cnt), 0);
        chk("rst_overflow", 32'(m.overflow), 0);
        chk("rst_dump_valid", 32'(m.dump_valid), 0);
        chk("rst_dump_data", 32'(m.dump_data), 0);
        chk("rst_dump_last", 32'(m.dump_last), 0);
        rst_n = 1'b1;
        m.arm = 1'b0;
        s.arm = 1'b0; s.bad = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_state", 32'(m.state_o), 0);
        chk("idle_tripped", 32'(m.tripped), 0);
        m.bad = 1'b0;

        // Short trace.
        arm_m();
        chk("s2_armed", 32'(m.state_o), 1);
        chk("s2_cnt0", 32'(m.cycle_cnt), 0);
        step(5'd1, 1'b0);
        step(5'd2, 1'b0);
        step(5'd3, 1'b1);
        chk("s2_tripped", 32'(m.tripped), 1);
        chk("s2_trip_cycle", 32'(m.trip_cycle), 2);
        chk("s2_cycle_cnt", 32'(m.cycle_cnt), 3);
        chk("s2_state", 32'(m.state_o), 2);
        dump_trace(1'b0, "s2");

        // Wrap-around: only the newest eight survive.
        arm_m();
        for (int v = 0; v < 12; v++) step(5'(v), v == 11);
        chk("s3_trip_cycle", 32'(m.trip_cycle), 11);
        chk("s3_cycle_cnt", 32'(m.cycle_cnt), 12);
        dump_trace(1'b0, "s3");

        // Backpressure and repeatable replay.
        arm_m();
        step(5'd1, 1'b0);
        step(5'd2, 1'b0);
        step(5'd3, 1'b1);
        dump_trace(1'b1, "s4a");
        dump_trace(1'b1, "s4b");

        // Violation beats a simultaneous arm.
        arm_m();
        step(5'd5, 1'b0);
        m.arm = 1'b1;
        step(5'd6, 1'b1);
        m.arm = 1'b0;
        chk("s5_bad_wins_state", 32'(m.state_o), 2);
        chk("s5_bad_wins_trip", 32'(m.trip_cycle), 1);
        // arm beats dump_req in TRIPPED.
        m.arm = 1'b1;
        m.dump_req = 1'b1;
        @(negedge clk);
        m.arm = 1'b0;
        m.dump_req = 1'b0;
        hist_q.delete();
        chk("s5_rearm_state", 32'(m.state_o), 1);
        chk("s5_rearm_cnt", 32'(m.cycle_cnt), 0);
        chk("s5_rearm_tripped", 32'(m.tripped), 0);
        chk("s5_rearm_valid", 32'(m.dump_valid), 0);
        // Restart while armed discards history.
        step(5'd9, 1'b0);
        step(5'd10, 1'b0);
        chk("s5_cnt2", 32'(m.cycle_cnt), 2);
        arm_m();
        chk("s5_restart_state", 32'(m.state_o), 1);
        chk("s5_restart_cnt", 32'(m.cycle_cnt), 0);
        step(5'd7, 1'b1);
        chk("s5_trip0", 32'(m.trip_cycle), 0);
        dump_trace(1'b0, "s5");
        // Reset mid-replay.
        m.dump_req = 1'b1;
        @(negedge clk);
        m.dump_req = 1'b0;
        chk("s5_dump_started", 32'(m.dump_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("s5_rst_valid", 32'(m.dump_valid), 0);
        chk("s5_rst_state", 32'(m.state_o), 0);

        // Saturating counter on the narrow instance.
        s.arm = 1'b1;
        @(negedge clk);
        s.arm = 1'b0;
        repeat (20) @(negedge clk);
        chk("s6_cnt_sat", 32'(s.cycle_cnt), 15);
        chk("s6_overflow", 32'(s.overflow), 1);
        s.bad = 1'b1;
        @(negedge clk);
        s.bad = 1'b0;
        chk("s6_trip_cycle", 32'(s.trip_cycle), 15);
        chk("s6_state", 32'(s.state_o), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
